// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential restoring divider. It divides a 2N-bit dividend by
//               an N-bit divisor and produces one quotient bit per clock.
//               The quotient is then converted to packed BCD by sequential
//               double-dabble for the display path. The start/finish
//               handshake is level-held.
// Ports       : clk       - rising-edge clock
//               reset     - asynchronous active-low reset
//               start     - request; sampled in IDLE, held until finish
//               dividend  - 2N-bit numerator, sampled on the load edge
//               divisor   - N-bit denominator, sampled on the load edge
//               quotient  - 2N-bit registered quotient
//               remainder - N-bit registered remainder
//               bcd       - 4*D-bit packed BCD of quotient, LS digit in [3:0]
//               div_zero  - last completed operation had divisor 0
//               finish    - high while in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int N = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [2*N-1:0]               dividend,
    input  logic [N-1:0]                 divisor,
    output logic [2*N-1:0]               quotient,
    output logic [N-1:0]                 remainder,
    output logic [4*(((2*N)/3)+1)-1:0]   bcd,
    output logic                         div_zero,
    output logic                         finish
);

    localparam int D  = ((2*N)/3)+1;
    localparam int CW = $clog2(2*N+1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_div  = 2'd1;
    localparam logic [1:0] c_st_bcd  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [CW-1:0] c_iter = CW'(2*N);

    logic [1:0]      r_state;
    logic [2*N-1:0]  r_q;
    logic [N-1:0]    r_m;
    // The partial remainder is always below M once a step completes, so only
    // N bits need storing; the N+1-bit shifted value lives in w_r_shift.
    logic [N-1:0]    r_r;
    logic [CW-1:0]   r_cnt;
    logic            r_zero;
    logic [2*N-1:0]  r_bin;
    logic [4*D-1:0]  r_bcd_work;

    logic [N:0]      w_r_shift;
    logic            w_r_ge;
    logic [N-1:0]    w_r_diff;
    logic [N-1:0]    w_r_next;
    logic [2*N-1:0]  w_q_next;
    logic [4*D-1:0]  w_bcd_adj;
    logic [4*D-1:0]  w_bcd_next;

    // One restoring step: shift {R,Q} left, subtract M when it fits.
    assign w_r_shift = {r_r, r_q[2*N-1]};
    assign w_r_ge    = (w_r_shift >= {1'b0, r_m});
    // Difference is below M whenever it is used, so N bits are exact.
    assign w_r_diff  = w_r_shift[N-1:0] - r_m;
    assign w_r_next  = w_r_ge ? w_r_diff : w_r_shift[N-1:0];
    assign w_q_next  = {r_q[2*N-2:0], w_r_ge};

    // Double-dabble: correct each digit >= 5 before the shift.
    generate
        for (genvar g = 0; g < D; g++) begin : g_dd_digit
            assign w_bcd_adj[4*g +: 4] = (r_bcd_work[4*g +: 4] >= 4'd5)
                                       ? (r_bcd_work[4*g +: 4] + 4'd3)
                                       : r_bcd_work[4*g +: 4];
        end
    endgenerate

    assign w_bcd_next = {w_bcd_adj[4*D-2:0], r_bin[2*N-1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_q        <= '0;
            r_m        <= '0;
            r_r        <= '0;
            r_cnt      <= '0;
            r_zero     <= 1'b0;
            r_bin      <= '0;
            r_bcd_work <= '0;
            quotient   <= '0;
            remainder  <= '0;
            bcd        <= '0;
            div_zero   <= 1'b0;
            finish     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_m        <= divisor;
                        r_r        <= '0;
                        r_cnt      <= c_iter;
                        r_bcd_work <= '0;
                        if (divisor == '0) begin
                            // Divide by zero skips DIV and reports all ones.
                            r_q     <= '1;
                            r_bin   <= '1;
                            r_zero  <= 1'b1;
                            r_state <= c_st_bcd;
                        end else begin
                            r_q     <= dividend;
                            r_zero  <= 1'b0;
                            r_state <= c_st_div;
                        end
                    end
                end

                c_st_div: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    // Keep the conversion copy tracking Q so it is ready
                    // when the last division step lands.
                    r_bin <= w_q_next;
                    if (r_cnt == CW'(1)) begin
                        r_cnt   <= c_iter;
                        r_state <= c_st_bcd;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end

                c_st_bcd: begin
                    r_bcd_work <= w_bcd_next;
                    r_bin      <= {r_bin[2*N-2:0], 1'b0};
                    r_cnt      <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        quotient  <= r_q;
                        remainder <= r_r;
                        bcd       <= w_bcd_next;
                        div_zero  <= r_zero;
                        finish    <= 1'b1;
                        r_state   <= c_st_done;
                    end
                end

                c_st_done: begin
                    if (!start) begin
                        finish  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end

                default: begin
                    finish  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider. Directed cases plus
//               randomized operations checked against an arithmetic model
//               (integer divide/modulo and decimal digit extraction).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int N = 5;
    localparam int D = ((2*N)/3)+1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2*N-1:0]    dividend;
    logic [N-1:0]      divisor;
    logic [2*N-1:0]    quotient;
    logic [N-1:0]      remainder;
    logic [4*D-1:0]    bcd;
    logic              div_zero;
    logic              finish;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.N(N)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .bcd       (bcd),
        .div_zero  (div_zero),
        .finish    (finish)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // One complete handshake, scrambling the inputs after the load edge.
    task automatic run_op(input int a, input int b);
        int  lat;
        bit  got;
        int  exp_q;
        int  exp_r;
        int  exp_lat;
        logic [31:0] exp_dz;
        if (b == 0) begin
            exp_q = (1 << (2*N)) - 1; exp_r = 0; exp_dz = 1; exp_lat = 2*N+1;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_dz = 0; exp_lat = 4*N+1;
        end
        @(negedge clk);
        dividend = (2*N)'(a);
        divisor  = N'(b);
        start    = 1'b1;
        got = 1'b0;
        lat = 0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            dividend = (2*N)'($urandom);
            divisor  = N'($urandom);
            if (finish) begin
                lat = e;
                got = 1'b1;
                break;
            end
        end
        check("finish_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("quotient", 32'(quotient), 32'(exp_q));
        check("remainder", 32'(remainder), 32'(exp_r));
        check("bcd", 32'(bcd), to_bcd(exp_q));
        check("div_zero", 32'(div_zero), exp_dz);
        @(posedge clk);
        #1;
        check("finish_hold", 32'(finish), 32'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("finish_drop", 32'(finish), 32'd0);
    endtask

    initial begin
        int rise_cnt;
        bit prev;
        int spurious;

        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases.
        run_op(780, 30);
        repeat (2) @(negedge clk);
        run_op(169, 13);
        run_op(1023, 7);
        run_op(5, 31);
        run_op(500, 0);
        run_op(100, 10);
        run_op(0, 1);
        run_op(1023, 1);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        dividend = 10'd780;
        divisor  = 5'd30;
        start    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        dividend = 10'd3;
        divisor  = 5'd2;
        repeat (7) @(posedge clk);
        #10;
        reset = 1'b0;
        #1;
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_div_zero", 32'(div_zero), 32'd0);
        check("abort_finish", 32'(finish), 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (finish) spurious++;
        end
        check("abort_no_finish", 32'(spurious), 32'd0);
        run_op(780, 30);

        // Start held high must complete exactly once.
        @(negedge clk);
        dividend = 10'd1000;
        divisor  = 5'd1;
        start    = 1'b1;
        rise_cnt = 0;
        prev     = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (finish && !prev) rise_cnt++;
            prev = finish;
        end
        check("hold_completions", 32'(rise_cnt), 32'd1);
        check("hold_finish", 32'(finish), 32'd1);
        check("hold_quotient", 32'(quotient), 32'd1000);
        check("hold_bcd", 32'(bcd), 32'h1000);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("hold_drop", 32'(finish), 32'd0);

        // Randomized operations, divisor zero included occasionally.
        for (int k = 0; k < 40; k++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 1023));
            b = (k % 8 == 7) ? 0 : int'($urandom_range(1, 31));
            run_op(a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
